lsu_n: RTL and testbench

- Load/store unit directly downstream of the execute-stage ALU.
- Takes the ALU result as the effective address and runs one single-outstanding transaction on a word-wide data-memory port.
- Produces the byte lanes and replicated write data for stores, and the aligned, sign- or zero-extended result for loads.
- Its output feeds the writeback mux alongside the ALU result.

---
 rtl/lsu_n.sv | 151 +++++++++++++++
 tb/tb_lsu_n.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/lsu_n.sv
// Load/store unit: single-outstanding word-port transactions with lane steering and load extension.
// LSU_MISALIGN_TRAP_EN: misaligned requests complete without a memory access and pulse misalign_o.
module lsu_n #(
    parameter int unsigned n = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         req_valid_i,
    output logic         req_ready_o,
    input  logic [3:0]   lsu_op_i,
    input  logic [n-1:0] addr_i,
    input  logic [n-1:0] store_data_i,
    output logic         mem_req_o,
    output logic         mem_we_o,
    output logic [n-1:0] mem_addr_o,
    output logic [3:0]   mem_be_o,
    output logic [n-1:0] mem_wdata_o,
    input  logic         mem_gnt_i,
    input  logic         mem_rvalid_i,
    input  logic [n-1:0] mem_rdata_i,
    output logic         done_o,
    output logic         ld_valid_o,
    output logic [n-1:0] ld_data_o,
    output logic         misalign_o
);

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;

    state_t       state_q, state_d;
    logic         legal, mis_d, trap_d, accept, capture;
    logic [1:0]   a;
    logic [3:0]   be_d;
    logic [n-1:0] wdata_d, ld_ext;
    logic [2:0]   op_q;
    logic [1:0]   lane_q;
    logic         load_q, trap_q;
    logic [7:0]   byte_sel;
    logic [15:0]  half_sel;

    assign a       = addr_i[1:0];
    assign accept  = req_valid_i & req_ready_o;
    assign trap_d  = TRAP && mis_d;
    assign capture = mem_rvalid_i & ((state_q == WAIT_R) | ((state_q == REQ) & mem_gnt_i & load_q));

    // Request decode: legality, lane enables, replicated write data, misalignment
    always_comb begin
        legal   = 1'b0;
        be_d    = 4'b1111;
        wdata_d = store_data_i;
        mis_d   = 1'b0;
        case (lsu_op_i)
            4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd8, 4'd9, 4'd10: legal = 1'b1;
            default: legal = 1'b0;
        endcase
        case (lsu_op_i[1:0])
            2'b00: begin
                be_d    = 4'b0001 << a;
                wdata_d = {(n/8){store_data_i[7:0]}};
            end
            2'b01: begin
                be_d    = 4'b0011 << {a[1], 1'b0};
                wdata_d = {(n/16){store_data_i[15:0]}};
                mis_d   = a[0];
            end
            default: begin
                be_d    = 4'b1111;
                wdata_d = store_data_i;
                mis_d   = |a;
            end
        endcase
    end

    // Load lane select; misaligned halves use lane[1] only, words always lane 0
    always_comb begin
        byte_sel = mem_rdata_i[{lane_q, 3'b000} +: 8];
        half_sel = mem_rdata_i[{lane_q[1], 4'b0000} +: 16];
        case (op_q[1:0])
            2'b00:   ld_ext = {{(n-8){byte_sel[7] & ~op_q[2]}}, byte_sel};
            2'b01:   ld_ext = {{(n-16){half_sel[15] & ~op_q[2]}}, half_sel};
            default: ld_ext = mem_rdata_i;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        req_ready_o = 1'b0;
        mem_req_o   = 1'b0;
        done_o      = 1'b0;
        ld_valid_o  = 1'b0;
        misalign_o  = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i)
                    state_d = (!legal || trap_d) ? DONE : REQ;
            end
            REQ: begin
                mem_req_o = 1'b1;
                if (mem_gnt_i)
                    state_d = (!load_q || mem_rvalid_i) ? DONE : WAIT_R;
            end
            WAIT_R: begin
                if (mem_rvalid_i)
                    state_d = DONE;
            end
            DONE: begin
                done_o     = 1'b1;
                ld_valid_o = load_q;
                misalign_o = trap_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_be_o    <= '0;
            mem_wdata_o <= '0;
            ld_data_o   <= '0;
            op_q        <= '0;
            lane_q      <= '0;
            load_q      <= 1'b0;
            trap_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                mem_addr_o  <= {addr_i[n-1:2], 2'b00};
                mem_be_o    <= be_d;
                mem_wdata_o <= wdata_d;
                mem_we_o    <= legal & lsu_op_i[3] & ~trap_d;
                op_q        <= lsu_op_i[2:0];
                lane_q      <= a;
                load_q      <= legal & ~lsu_op_i[3] & ~trap_d;
                trap_q      <= legal & trap_d;
            end
            if (capture)
                ld_data_o <= ld_ext;
        end
    end

endmodule

// File: tb/tb_lsu_n.sv
// Directed bench for lsu_n: bench-side model pushes expected completions to a scoreboard queue.
// Also built with LSU_MISALIGN_TRAP_EN to check the trapping variant.
module tb_lsu_n;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [3:0]  lsu_op_i = '0;
    logic [31:0] addr_i = '0;
    logic [31:0] store_data_i = '0;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic        done_o, ld_valid_o, misalign_o;
    logic [31:0] ld_data_o;

    lsu_n #(.n(32)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .lsu_op_i(lsu_op_i), .addr_i(addr_i), .store_data_i(store_data_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o),
        .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i), .done_o(done_o), .ld_valid_o(ld_valid_o),
        .ld_data_o(ld_data_o), .misalign_o(misalign_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        ldv;
        logic        mis;
        logic        req;
        logic [31:0] ld;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_err = 0;
    logic [31:0] ld_hold = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Drive one request, act as memory with given grant / rvalid delays (rvd<0: rvalid with grant)
    task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rd, input int gd, input int rvd);
        logic        legal, is_store, mis, trapped;
        logic [1:0]  a;
        logic [3:0]  ebe;
        logic [31:0] ewd, eld, sh;
        exp_t        e, got;
        int          cyc, waited, rv_cnt;
        bit          granted, saw_req;

        a        = addr[1:0];
        legal    = (op inside {4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd8, 4'd9, 4'd10});
        is_store = op[3];
        mis      = (op[1:0] == 2'b01 && a[0]) || (op[1:0] == 2'b10 && a != 2'b00);
        trapped  = TRAP && mis;
        sh       = rd >> (8 * a);
        if (op[1:0] == 2'b00) begin
            ebe = (a == 0) ? 4'b0001 : (a == 1) ? 4'b0010 : (a == 2) ? 4'b0100 : 4'b1000;
            ewd = {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
            eld = op[2] ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
        end else if (op[1:0] == 2'b01) begin
            ebe = a[1] ? 4'b1100 : 4'b0011;
            ewd = {wd[15:0], wd[15:0]};
            sh  = a[1] ? {16'h0, rd[31:16]} : {16'h0, rd[15:0]};
            eld = op[2] ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
        end else begin
            ebe = 4'b1111;
            ewd = wd;
            eld = rd;
        end

        e.req = legal && !trapped;
        e.ldv = legal && !trapped && !is_store;
        e.mis = legal && trapped;
        if (e.ldv) ld_hold = eld;
        e.ld  = ld_hold;
        if (!e.req) e.lat = 1;
        else if (is_store || rvd < 0) e.lat = 2 + gd;
        else e.lat = 2 + gd + rvd + 1;
        sb.push_back(e);

        chk({tag, ".ready"}, req_ready_o, 1'b1);
        req_valid_i = 1'b1; lsu_op_i = op; addr_i = addr; store_data_i = wd;
        step();
        req_valid_i = 1'b0; lsu_op_i = 4'hF; addr_i = '1; store_data_i = '1;
        cyc = 1; waited = 0; rv_cnt = 0; granted = 0; saw_req = 0;
        while (!done_o && cyc < 60) begin
            if (mem_req_o) begin
                saw_req = 1;
                chk({tag, ".addr"}, mem_addr_o, {addr[31:2], 2'b00});
                chk({tag, ".be"}, mem_be_o, ebe);
                chk({tag, ".we"}, mem_we_o, is_store);
                if (is_store) chk({tag, ".wdata"}, mem_wdata_o, ewd);
                chk({tag, ".busy"}, req_ready_o, 1'b0);
                if (waited == gd) begin
                    mem_gnt_i = 1'b1;
                    granted   = 1;
                    if (!is_store && rvd < 0) begin mem_rvalid_i = 1'b1; mem_rdata_i = rd; end
                end else waited++;
            end else if (granted) begin
                if (rv_cnt == rvd) begin mem_rvalid_i = 1'b1; mem_rdata_i = rd; end
                else rv_cnt++;
            end
            step();
            mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h5A5A_5A5A;
            cyc++;
        end
        got = sb.pop_front();
        chk({tag, ".done_seen"}, done_o, 1'b1);
        chk({tag, ".latency"}, cyc, got.lat);
        chk({tag, ".mem_req_seen"}, saw_req, got.req);
        chk({tag, ".ld_valid"}, ld_valid_o, got.ldv);
        chk({tag, ".misalign"}, misalign_o, got.mis);
        chk({tag, ".ld_data"}, ld_data_o, got.ld);
        step();
        chk({tag, ".done_clr"}, done_o, 1'b0);
        chk({tag, ".ready_back"}, req_ready_o, 1'b1);
        chk({tag, ".ld_held"}, ld_data_o, got.ld);
    endtask

    task automatic chk_all_idle(input string tag);
        chk({tag, ".ready"}, req_ready_o, 1'b1);
        chk({tag, ".req"}, mem_req_o, 1'b0);
        chk({tag, ".we"}, mem_we_o, 1'b0);
        chk({tag, ".done"}, done_o, 1'b0);
        chk({tag, ".ldv"}, ld_valid_o, 1'b0);
        chk({tag, ".mis"}, misalign_o, 1'b0);
        chk({tag, ".addr"}, mem_addr_o, 32'h0);
        chk({tag, ".be"}, mem_be_o, 4'h0);
        chk({tag, ".wdata"}, mem_wdata_o, 32'h0);
        chk({tag, ".lddata"}, ld_data_o, 32'h0);
    endtask

    initial begin
        step();
        step();
        chk_all_idle("reset");
        rst_ni = 1'b1;
        step();

        do_op("sw",     4'd10, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,         0, -1);
        do_op("sb",     4'd8,  32'h0000_0103, 32'h0000_00A5, 32'h0,         0, -1);
        do_op("sh",     4'd9,  32'h0000_0102, 32'h1234_BEEF, 32'h0,         1, -1);
        do_op("lb",     4'd0,  32'h0000_0202, 32'h0,         32'h12F0_3456, 0,  2);
        do_op("lbu",    4'd4,  32'h0000_0202, 32'h0,         32'h12F0_3456, 0,  2);
        do_op("lh",     4'd1,  32'h0000_0202, 32'h0,         32'h12F0_3456, 0, -1);
        do_op("lh_neg", 4'd1,  32'h0000_0200, 32'h0,         32'h0000_8001, 0,  0);
        do_op("lhu",    4'd5,  32'h0000_0200, 32'h0,         32'h0000_8001, 2, -1);
        do_op("lw_gd4", 4'd2,  32'h0000_0300, 32'h0,         32'hCAFE_F00D, 4,  1);
        do_op("illegal",4'd3,  32'h0000_0304, 32'h0,         32'h1111_1111, 0, -1);
        do_op("lw_mis", 4'd2,  32'h0000_0101, 32'h0,         32'h8765_4321, 0, -1);
        do_op("sh_mis", 4'd9,  32'h0000_0101, 32'h0000_ABCD, 32'h0,         0, -1);
        do_op("lb_b3",  4'd0,  32'h0000_0503, 32'h0,         32'h7F00_0000, 0,  0);

        // Reset while waiting for read data; the late rvalid must be ignored
        req_valid_i = 1'b1; lsu_op_i = 4'd2; addr_i = 32'h0000_0400;
        step();
        req_valid_i = 1'b0;
        mem_gnt_i = 1'b1;
        step();
        mem_gnt_i = 1'b0;
        chk("rst_mid.in_wait", mem_req_o, 1'b0);
        chk("rst_mid.busy", req_ready_o, 1'b0);
        rst_ni = 1'b0;
        #1;
        chk_all_idle("rst_async");
        step();
        rst_ni = 1'b1;
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hFFFF_FFFF;
        step();
        mem_rvalid_i = 1'b0;
        chk_all_idle("late_rvalid");
        step();
        chk_all_idle("late_rvalid2");
        chk("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
